// File: rtl/piece_sequencer_if.sv
// Handshake and lookup signals between the game FSM, shape lookup and the piece sequencer.
interface piece_sequencer_if;
  logic        spawn_req;
  logic        rotate_req;
  logic        rotate_dir;
  logic [15:0] block_matrix;
  logic [2:0]  block_num;
  logic [2:0]  cur_block_num;
  logic [2:0]  next_block_num;
  logic [15:0] cur_matrix;
  logic [1:0]  rot_state;
  logic        spawn_ack;
  logic        rotate_done;
  logic        piece_valid;
  logic        busy;

  modport master (
    output spawn_req, rotate_req, rotate_dir, block_matrix,
    input  block_num, cur_block_num, next_block_num, cur_matrix, rot_state,
    input  spawn_ack, rotate_done, piece_valid, busy
  );

  modport slave (
    input  spawn_req, rotate_req, rotate_dir, block_matrix,
    output block_num, cur_block_num, next_block_num, cur_matrix, rot_state,
    output spawn_ack, rotate_done, piece_valid, busy
  );
endinterface

// File: rtl/piece_sequencer.sv
// Falling-piece sequencer: LFSR draw with one-piece preview, shape latch and in-place rotation.
module piece_sequencer #(
  parameter int unsigned NUM_BLOCKS = 5,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5,
  parameter bit          NO_REPEAT  = 1'b1,
  parameter int unsigned MAX_DRAW   = 16
) (
  input logic              clk,
  input logic              rst,
  piece_sequencer_if.slave bus
);

  localparam logic [7:0]      SeedEff   = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam int unsigned     CntW      = (MAX_DRAW < 2) ? 1 : $clog2(MAX_DRAW);
  localparam logic [CntW-1:0] CntLast   = CntW'(MAX_DRAW - 1);
  localparam logic [2:0]      LastBlock = 3'(NUM_BLOCKS - 1);

  typedef enum logic [1:0] {StIdle, StDraw, StLoad} state_e;

  state_e          state_q, state_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      cur_q, cur_d, next_q, next_d;
  logic [15:0]     mat_q, mat_d;
  logic [1:0]      rot_q, rot_d;
  logic            ack_q, ack_d, done_q, done_d, valid_q, valid_d;

  logic [2:0] cand, fallback;
  logic       cand_ok;

  // Bit 15-(4r+c) holds row r, column c.
  function automatic logic [15:0] rot_cw(input logic [15:0] m);
    logic [15:0] o;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[15-(4*r+c)] = m[15-(4*(3-c)+r)];
      end
    end
    return o;
  endfunction

  function automatic logic [15:0] rot_ccw(input logic [15:0] m);
    logic [15:0] o;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[15-(4*r+c)] = m[15-(4*c+(3-r))];
      end
    end
    return o;
  endfunction

  assign cand     = lfsr_q[2:0];
  assign cand_ok  = (32'(cand) < NUM_BLOCKS) && (!NO_REPEAT || (cand != next_q));
  assign fallback = (next_q == LastBlock) ? 3'd0 : next_q + 3'd1;
  assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    next_d  = next_q;
    mat_d   = mat_q;
    rot_d   = rot_q;
    valid_d = valid_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Spawn has priority; a simultaneous rotate is dropped.
        if (bus.spawn_req) begin
          state_d = StDraw;
          cnt_d   = '0;
        end else if (bus.rotate_req && valid_q) begin
          mat_d  = bus.rotate_dir ? rot_ccw(mat_q) : rot_cw(mat_q);
          rot_d  = bus.rotate_dir ? rot_q - 2'd1 : rot_q + 2'd1;
          done_d = 1'b1;
        end
      end
      StDraw: begin
        if (cand_ok) begin
          cur_d   = next_q;
          next_d  = cand;
          state_d = StLoad;
        end else if (cnt_q == CntLast) begin
          cur_d   = next_q;
          next_d  = fallback;
          state_d = StLoad;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StLoad: begin
        // block_num already carries the new piece, so the lookup output is current.
        mat_d   = bus.block_matrix;
        rot_d   = 2'd0;
        ack_d   = 1'b1;
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      lfsr_q  <= SeedEff;
      cnt_q   <= '0;
      cur_q   <= 3'd0;
      next_q  <= 3'd0;
      mat_q   <= 16'h0000;
      rot_q   <= 2'd0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      next_q  <= next_d;
      mat_q   <= mat_d;
      rot_q   <= rot_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  assign bus.block_num      = cur_q;
  assign bus.cur_block_num  = cur_q;
  assign bus.next_block_num = next_q;
  assign bus.cur_matrix     = mat_q;
  assign bus.rot_state      = rot_q;
  assign bus.spawn_ack      = ack_q;
  assign bus.rotate_done    = done_q;
  assign bus.piece_valid    = valid_q;
  assign bus.busy           = (state_q != StIdle);

endmodule

// File: tb/tb_piece_sequencer.sv
// Scoreboard bench for piece_sequencer: default instance plus a small instance that hits the fallback.
module tb_piece_sequencer;

  logic clk = 1'b0;
  logic rst, rst_b;
  always #5 clk = ~clk;

  piece_sequencer_if ifa ();
  piece_sequencer_if ifb ();

  piece_sequencer #(
    .NUM_BLOCKS(5), .LFSR_SEED(8'hA5), .NO_REPEAT(1'b1), .MAX_DRAW(16)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );

  piece_sequencer #(
    .NUM_BLOCKS(3), .LFSR_SEED(8'h00), .NO_REPEAT(1'b1), .MAX_DRAW(2)
  ) dut_b (
    .clk(clk), .rst(rst_b), .bus(ifb)
  );

  typedef struct {
    bit          spawn;
    int          cyc;
    int          cur;
    int          nxt;
    logic [15:0] mat;
    int          rot;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] ml_a, ml_b;
  int          m_cur, m_next, m_rot, mb_cur, mb_next;
  logic [15:0] m_mat;
  bit          m_valid;
  logic [31:0] outs_a;

  function automatic logic [15:0] lut(input logic [2:0] n);
    case (n)
      3'd0:    return 16'h2222;
      3'd1:    return 16'h0660;
      3'd2:    return 16'h0E40;
      3'd3:    return 16'h0C60;
      3'd4:    return 16'h4460;
      default: return 16'hFFFF;
    endcase
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Quarter turn via an explicit grid: cw out[r][c]=in[3-c][r], ccw out[r][c]=in[c][3-r].
  function automatic logic [15:0] rot_model(input logic [15:0] m, input bit ccw);
    bit g[4][4];
    logic [15:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) g[r][c] = m[15-(4*r+c)];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) o[15-(4*r+c)] = ccw ? g[c][3-r] : g[3-c][r];
    return o;
  endfunction

  // Walks the LFSR sequence from the first DRAW cycle; d is the number of DRAW cycles.
  task automatic draw(input logic [7:0] l0, input int nxt, input int num, input int maxd,
                      output int cand, output int d);
    logic [7:0] l;
    bit found;
    l = l0;
    found = 1'b0;
    cand = (nxt + 1) % num;
    d = maxd;
    for (int k = 0; k < maxd && !found; k++) begin
      if (int'(l[2:0]) < num && int'(l[2:0]) != nxt) begin
        cand = int'(l[2:0]);
        d = k + 1;
        found = 1'b1;
      end
      l = lfsr_step(l);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always_comb ifa.block_matrix = lut(ifa.block_num);
  always_comb ifb.block_matrix = lut(ifb.block_num);

  assign outs_a = {1'b0, ifa.block_num, ifa.cur_block_num, ifa.next_block_num, ifa.cur_matrix,
                   ifa.rot_state, ifa.spawn_ack, ifa.rotate_done, ifa.piece_valid, ifa.busy};

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    ml_a <= rst ? 8'hA5 : lfsr_step(ml_a);
    ml_b <= rst_b ? 8'h01 : lfsr_step(ml_b);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (ifa.spawn_ack || ifa.rotate_done) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_pulse", 32'({ifa.spawn_ack, ifa.rotate_done}), 32'd0);
        end else begin
          ea = qa.pop_front();
          chk("a_pulse_kind", 32'({ifa.spawn_ack, ifa.rotate_done}), ea.spawn ? 32'd2 : 32'd1);
          chk("a_pulse_cycle", cyc, ea.cyc);
          chk("a_cur_block", 32'(ifa.cur_block_num), ea.cur);
          chk("a_block_num", 32'(ifa.block_num), ea.cur);
          chk("a_next_block", 32'(ifa.next_block_num), ea.nxt);
          chk("a_cur_matrix", 32'(ifa.cur_matrix), 32'(ea.mat));
          chk("a_rot_state", 32'(ifa.rot_state), ea.rot);
          chk("a_piece_valid", 32'(ifa.piece_valid), 32'd1);
          chk("a_busy_idle", 32'(ifa.busy), 32'd0);
        end
      end else if (qa.size() != 0 && cyc > qa[0].cyc) begin
        chk("a_missing_pulse", cyc, qa[0].cyc);
        void'(qa.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_b) begin
      if (ifb.spawn_ack || ifb.rotate_done) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_pulse", 32'({ifb.spawn_ack, ifb.rotate_done}), 32'd0);
        end else begin
          eb = qb.pop_front();
          chk("b_pulse_kind", 32'({ifb.spawn_ack, ifb.rotate_done}), 32'd2);
          chk("b_pulse_cycle", cyc, eb.cyc);
          chk("b_cur_block", 32'(ifb.cur_block_num), eb.cur);
          chk("b_next_block", 32'(ifb.next_block_num), eb.nxt);
          chk("b_cur_matrix", 32'(ifb.cur_matrix), 32'(eb.mat));
          chk("b_rot_state", 32'(ifb.rot_state), 32'd0);
        end
      end else if (qb.size() != 0 && cyc > qb[0].cyc) begin
        chk("b_missing_pulse", cyc, qb[0].cyc);
        void'(qb.pop_front());
      end
    end
  end

  // One IDLE-cycle operation on instance A; returns at the next IDLE negedge.
  task automatic op(input bit sp, input bit ro, input bit dir);
    exp_t e;
    int cand, d;
    ifa.spawn_req  = sp;
    ifa.rotate_req = ro;
    ifa.rotate_dir = dir;
    if (sp) begin
      draw(lfsr_step(ml_a), m_next, 5, 16, cand, d);
      m_cur = m_next;
      m_next = cand;
      m_mat = lut(3'(m_cur));
      m_rot = 0;
      m_valid = 1'b1;
      e.spawn = 1'b1; e.cyc = cyc + d + 2; e.cur = m_cur; e.nxt = m_next;
      e.mat = m_mat; e.rot = 0;
      qa.push_back(e);
      for (int k = 1; k <= d + 1; k++) begin
        @(negedge clk);
        chk("a_busy_during_spawn", 32'(ifa.busy), 32'd1);
        ifa.spawn_req  = 1'($urandom);
        ifa.rotate_req = 1'($urandom);
        ifa.rotate_dir = 1'($urandom);
      end
      @(negedge clk);
    end else begin
      if (ro && m_valid) begin
        m_mat = rot_model(m_mat, dir);
        m_rot = (m_rot + (dir ? 3 : 1)) % 4;
        e.spawn = 1'b0; e.cyc = cyc + 1; e.cur = m_cur; e.nxt = m_next;
        e.mat = m_mat; e.rot = m_rot;
        qa.push_back(e);
      end
      @(negedge clk);
    end
    ifa.spawn_req  = 1'b0;
    ifa.rotate_req = 1'b0;
  endtask

  task automatic model_reset_a();
    m_cur = 0; m_next = 0; m_rot = 0; m_mat = 16'h0000; m_valid = 1'b0;
  endtask

  // Reset lands on the DRAW (off=1) or LOAD (off=d+1) edge of a spawn; no ack may follow.
  task automatic abort(input bit in_load);
    int cand, d;
    draw(lfsr_step(ml_a), m_next, 5, 16, cand, d);
    ifa.spawn_req = 1'b1;
    @(negedge clk);
    ifa.spawn_req = 1'b0;
    repeat (in_load ? d : 0) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset_a();
    chk(in_load ? "abort_load_outputs" : "abort_draw_outputs", outs_a, 32'd0);
    repeat (12) @(negedge clk);
    chk("abort_no_ack_outputs", outs_a, 32'd0);
  endtask

  task automatic spawn_b();
    exp_t e;
    int cand, d;
    draw(lfsr_step(ml_b), mb_next, 3, 2, cand, d);
    mb_cur = mb_next;
    mb_next = cand;
    e.spawn = 1'b1; e.cyc = cyc + d + 2; e.cur = mb_cur; e.nxt = mb_next;
    e.mat = lut(3'(mb_cur)); e.rot = 0;
    qb.push_back(e);
    ifb.spawn_req = 1'b1;
    @(negedge clk);
    ifb.spawn_req = 1'b0;
    repeat (d + 1) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int r;
    rst = 1'b1; rst_b = 1'b1;
    ifa.spawn_req = 1'b0; ifa.rotate_req = 1'b0; ifa.rotate_dir = 1'b0;
    ifb.spawn_req = 1'b0; ifb.rotate_req = 1'b0; ifb.rotate_dir = 1'b0;
    model_reset_a();
    mb_cur = 0; mb_next = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("reset_outputs", outs_a, 32'd0);
    end

    op(1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("rotate_before_spawn", 32'(ifa.cur_matrix), 32'd0);

    op(1'b1, 1'b0, 1'b0);
    chk("first_cur", 32'(ifa.cur_block_num), 32'd0);
    chk("first_matrix", 32'(ifa.cur_matrix), 32'h2222);
    chk("first_next_range", 32'(ifa.next_block_num >= 3'd1 && ifa.next_block_num <= 3'd4), 32'd1);

    op(1'b0, 1'b1, 1'b0);
    chk("cw_2222", 32'(ifa.cur_matrix), 32'h00F0);
    chk("cw_rot1", 32'(ifa.rot_state), 32'd1);
    repeat (3) op(1'b0, 1'b1, 1'b0);
    chk("four_cw", 32'(ifa.cur_matrix), 32'h2222);
    chk("four_cw_rot", 32'(ifa.rot_state), 32'd0);
    op(1'b0, 1'b1, 1'b0);
    op(1'b0, 1'b1, 1'b1);
    chk("cw_then_ccw", 32'(ifa.cur_matrix), 32'h2222);

    for (int i = 0; i < 40 && m_cur != 1; i++) op(1'b1, 1'b0, 1'b0);
    chk("reach_square", 32'(ifa.cur_block_num), 32'd1);
    op(1'b0, 1'b1, 1'b0);
    chk("square_cw", 32'(ifa.cur_matrix), 32'h0660);
    chk("square_cw_rot", 32'(ifa.rot_state), 32'd1);
    op(1'b0, 1'b1, 1'b1);
    op(1'b0, 1'b1, 1'b1);
    chk("square_ccw", 32'(ifa.cur_matrix), 32'h0660);
    chk("square_ccw_rot", 32'(ifa.rot_state), 32'd3);

    op(1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 7);
      if (r < 2) op(1'b1, r == 1, 1'($urandom));
      else if (r < 6) op(1'b0, 1'b1, 1'($urandom));
      else op(1'b0, 1'b0, 1'b0);
    end
    repeat (2) @(negedge clk);

    abort(1'b0);
    op(1'b1, 1'b0, 1'b0);
    abort(1'b1);
    op(1'b1, 1'b0, 1'b0);
    chk("recover_matrix", 32'(ifa.cur_matrix), 32'h2222);
    repeat (3) @(negedge clk);

    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 30; i++) spawn_b();
    repeat (4) @(negedge clk);

    chk("queues_drained", 32'(qa.size() + qb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/piece_sequencer.md
Name: piece_sequencer

Overview:
- Sequences the falling-piece resource for the game controller.
- Draws the next piece number (0..4) from a free-running LFSR and keeps a one-piece preview.
- Drives the piece-shape lookup with the current number, latches its 16-bit 4x4 matrix on spawn, and rotates that matrix in place on request.
- Sits between the game FSM (spawn/rotate handshakes) and the shape lookup / collision logic.

Parameters:
- NUM_BLOCKS, 5, number of valid piece numbers (0..NUM_BLOCKS-1); legal range 2..8.
- LFSR_SEED, 8'hA5, LFSR reset value; a value of 0 is replaced by 8'h01.
- NO_REPEAT, 1, when 1 a drawn piece must differ from the current preview.
- MAX_DRAW, 16, maximum DRAW cycles before the deterministic fallback.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- spawn_req  input  1  request a new piece; sampled in IDLE only.
- rotate_req  input  1  request a quarter turn; sampled in IDLE only.
- rotate_dir  input  1  0 = clockwise, 1 = counter-clockwise; sampled with rotate_req.
- block_matrix  input  16  shape from the lookup for block_num.
- block_num  output  3  equals cur_block_num at all times; drives the lookup.
- cur_block_num  output  3  current piece number.
- next_block_num  output  3  preview piece number.
- cur_matrix  output  16  current (rotated) 4x4 matrix.
- rot_state  output  2  quarter turns applied, modulo 4.
- spawn_ack  output  1  one-cycle pulse when the new piece is loaded.
- rotate_done  output  1  one-cycle pulse when a rotation completes.
- piece_valid  output  1  0 after reset; 1 from the first spawn_ack onward.
- busy  output  1  1 whenever state is not IDLE.

Behaviour:
- Reset (synchronous, rst=1 at the clk edge):
  - state=IDLE; lfsr=LFSR_SEED (or 8'h01 if the seed is 0).
  - cur_block_num=0, next_block_num=0, cur_matrix=16'h0000, rot_state=0.
  - spawn_ack=0, rotate_done=0, piece_valid=0, busy=0; draw counter=0.
  - Reset asserted mid-DRAW or mid-LOAD aborts the operation; no ack is produced.
- LFSR:
  - 8-bit, shifts every cycle in every state except reset: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - The sampled candidate is lfsr[2:0].
- Matrix layout: row r (0..3), column c (0..3) maps to bit 15-(4r+c); row 0 is the MSB nibble.
- Rotation:
  - Clockwise: out[r][c] = in[3-c][r].
  - Counter-clockwise: out[r][c] = in[c][3-r].
- State machine IDLE / DRAW / LOAD:
  - IDLE with spawn_req=1: go to DRAW and clear the draw counter. spawn_req wins over a simultaneous rotate_req; that rotate_req is dropped.
  - IDLE with rotate_req=1, piece_valid=1 and spawn_req=0: on the next edge, cur_matrix <= rotated matrix. rot_state increments by 1 for clockwise and decrements by 1 for counter-clockwise, both mod 4. rotate_done pulses for that one cycle. State stays IDLE, so back-to-back rotates are accepted every cycle.
  - IDLE with rotate_req=1 and piece_valid=0: request ignored, no rotate_done.
  - DRAW, each cycle the candidate is accepted when it is < NUM_BLOCKS and (NO_REPEAT=0 or candidate != next_block_num).
  - DRAW accept: cur_block_num <= next_block_num; next_block_num <= candidate; go to LOAD.
  - DRAW with no accept after MAX_DRAW cycles: candidate = (next_block_num+1) mod NUM_BLOCKS, then the accept actions above.
  - The draw counter increments on each rejected DRAW cycle.
  - LOAD (one cycle): block_num already shows the new cur_block_num. cur_matrix <= block_matrix; rot_state <= 0; spawn_ack=1 in the following cycle; piece_valid <= 1; return to IDLE.
- Requests are level-sampled only in IDLE. spawn_req and rotate_req held while busy=1 are ignored until IDLE.
- Spawn latency: spawn_req edge to spawn_ack is between 3 and MAX_DRAW+2 cycles.
- next_block_num is always < NUM_BLOCKS.
- Lookup contract: block_matrix must be valid combinationally in the same cycle as block_num; no lookup latency is tolerated.

Test Plan:
- Reset with LFSR_SEED=8'hA5, release rst, hold all requests low for 10 cycles -> all outputs 0, busy=0; lfsr matches the software model for every cycle.
- spawn_req pulse with lookup giving 16'h2222 for piece 0 -> spawn_ack pulses once within 18 cycles. cur_block_num=0 (previous preview). cur_matrix=16'h2222. next_block_num is in 1..4 (NO_REPEAT=1). rot_state=0.
- With cur_matrix=16'h2222, rotate_req=1 with rotate_dir=0 -> cur_matrix=16'h00F0, rot_state=1. Four consecutive clockwise rotates -> back to 16'h2222, rot_state=0. One clockwise then one counter-clockwise -> 16'h2222.
- Load 16'h0660 -> clockwise and counter-clockwise rotates leave cur_matrix=16'h0660; rot_state still changes.
- spawn_req and rotate_req asserted together in IDLE -> only the spawn occurs; no rotate_done. rotate_req before the first spawn -> ignored.
- Force the LFSR to yield only rejected candidates (model check) -> after MAX_DRAW cycles next_block_num = (old_next+1) mod 5. Assert rst during DRAW -> no spawn_ack, outputs return to reset values.
